// File: rtl/adpll_gain_sweeper.sv
// Steps the ADPLL kp/ki gains over a grid and scores each point by its integrated |error|.
// Optional macro GAIN_SWEEP_EARLY_ABORT_EN ends a measurement window early on a large error.
module adpll_gain_sweeper #(
    parameter int KP_WIDTH      = 5,
    parameter int KI_WIDTH      = 7,
    parameter int ERR_WIDTH     = 8,
    parameter int KP_MAX        = 15,
    parameter int KI_MAX        = 15,
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 4096,
    parameter int MEAS_CYCLES   = 4096,
    parameter int ACC_WIDTH     = 24
`ifdef GAIN_SWEEP_EARLY_ABORT_EN
    , parameter int ABORT_THRESH = 100
`endif
) (
    input  logic                        fpga_clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic signed [ERR_WIDTH-1:0] error_i,
    output logic                        enable_o,
    output logic [KP_WIDTH-1:0]         kp_o,
    output logic [KI_WIDTH-1:0]         ki_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [KP_WIDTH-1:0]         best_kp_o,
    output logic [KI_WIDTH-1:0]         best_ki_o,
    output logic [ACC_WIDTH-1:0]        best_score_o
);

    localparam int CNT_MAX0 = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > MEAS_CYCLES) ? CNT_MAX0 : MEAS_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [KP_WIDTH-1:0] KP_LAST = KP_WIDTH'(KP_MAX);
    localparam logic [KI_WIDTH-1:0] KI_LAST = KI_WIDTH'(KI_MAX);
    localparam logic [KP_WIDTH-1:0] KP_ONE  = KP_WIDTH'(1);
    localparam logic [KI_WIDTH-1:0] KI_ONE  = KI_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_SETTLE, S_MEASURE, S_COMPARE, S_DONE
    } state_t;

    state_t                 r_state, w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [KP_WIDTH-1:0]    r_kp, r_best_kp;
    logic [KI_WIDTH-1:0]    r_ki, r_best_ki;
    logic [ACC_WIDTH-1:0]   r_acc, r_best_score;
    logic [ACC_WIDTH-1:0]   w_abs_ext;
    logic                   w_hold_end, w_settle_end, w_meas_end;
    logic                   w_ki_more, w_kp_more, w_spike;

    // Magnitude in ERR_WIDTH unsigned bits, so the most negative code maps to 2^(ERR_WIDTH-1).
    function automatic logic [ERR_WIDTH-1:0] abs_err(input logic [ERR_WIDTH-1:0] e);
        return e[ERR_WIDTH-1] ? (~e + ERR_WIDTH'(1)) : e;
    endfunction

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
    endfunction

    assign w_abs_ext    = {{(ACC_WIDTH-ERR_WIDTH){1'b0}}, abs_err(error_i)};
    assign w_hold_end   = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign w_settle_end = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign w_meas_end   = (r_cnt == CNT_W'(MEAS_CYCLES - 1));
    assign w_ki_more    = (r_ki < KI_LAST);
    assign w_kp_more    = (r_kp < KP_LAST);

`ifdef GAIN_SWEEP_EARLY_ABORT_EN
    assign w_spike = (r_state == S_MEASURE) && (w_abs_ext > ACC_WIDTH'(ABORT_THRESH));
`else
    assign w_spike = 1'b0;
`endif

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_next = S_HOLD;
            S_HOLD:    if (w_hold_end) w_next = S_SETTLE;
            S_SETTLE:  if (w_settle_end) w_next = S_MEASURE;
            S_MEASURE: if (w_meas_end || w_spike) w_next = S_COMPARE;
            S_COMPARE: w_next = (w_ki_more || w_kp_more) ? S_HOLD : S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        // Abort overrides everything, including a start arriving in the same cycle.
        if (abort_i) w_next = S_IDLE;
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i || r_state == S_IDLE || w_next != r_state) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            r_kp         <= '0;
            r_ki         <= '0;
            r_acc        <= '0;
            r_best_kp    <= '0;
            r_best_ki    <= '0;
            r_best_score <= '1;
        end else if (abort_i) begin
            r_kp <= '0;
            r_ki <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_kp         <= KP_ONE;
                        r_ki         <= KI_ONE;
                        r_best_score <= '1;
                    end
                end
                S_SETTLE:  r_acc <= '0;
                S_MEASURE: r_acc <= w_spike ? {ACC_WIDTH{1'b1}} : sat_add(r_acc, w_abs_ext);
                S_COMPARE: begin
                    // Strict compare: on a tie the earlier grid point stays best.
                    if (r_acc < r_best_score) begin
                        r_best_score <= r_acc;
                        r_best_kp    <= r_kp;
                        r_best_ki    <= r_ki;
                    end
                    if (w_ki_more) begin
                        r_ki <= r_ki + KI_ONE;
                    end else if (w_kp_more) begin
                        r_ki <= KI_ONE;
                        r_kp <= r_kp + KP_ONE;
                    end
                end
                S_DONE: begin
                    r_kp <= '0;
                    r_ki <= '0;
                end
                default: ;
            endcase
        end
    end

    assign enable_o     = (r_state == S_SETTLE) || (r_state == S_MEASURE) || (r_state == S_COMPARE);
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);
    assign kp_o         = r_kp;
    assign ki_o         = r_ki;
    assign best_kp_o    = r_best_kp;
    assign best_ki_o    = r_best_ki;
    assign best_score_o = r_best_score;

endmodule

// File: tb/tb_adpll_gain_sweeper.sv
// Directed bench for adpll_gain_sweeper on a 2x2 grid with short hold/settle/measure windows.
// Define GAIN_SWEEP_EARLY_ABORT_EN to also exercise the early-abort path.
module tb_adpll_gain_sweeper;

    logic              fpga_clk_i = 1'b0;
    logic              reset_i;
    logic              start_i;
    logic              abort_i;
    logic signed [7:0] error_i;
    logic              enable_o;
    logic [4:0]        kp_o;
    logic [6:0]        ki_o;
    logic              busy_o;
    logic              done_o;
    logic [4:0]        best_kp_o;
    logic [6:0]        best_ki_o;
    logic [23:0]       best_score_o;

    int errors = 0;
    int checks = 0;

    always #5 fpga_clk_i = ~fpga_clk_i;

    adpll_gain_sweeper #(
        .KP_WIDTH(5), .KI_WIDTH(7), .ERR_WIDTH(8),
        .KP_MAX(2), .KI_MAX(2),
        .HOLD_CYCLES(2), .SETTLE_CYCLES(4), .MEAS_CYCLES(4),
        .ACC_WIDTH(24)
`ifdef GAIN_SWEEP_EARLY_ABORT_EN
        , .ABORT_THRESH(100)
`endif
    ) dut (
        .fpga_clk_i(fpga_clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
        .error_i(error_i), .enable_o(enable_o), .kp_o(kp_o), .ki_o(ki_o),
        .busy_o(busy_o), .done_o(done_o), .best_kp_o(best_kp_o), .best_ki_o(best_ki_o),
        .best_score_o(best_score_o)
    );

    task automatic tick();
        @(posedge fpga_clk_i);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        checks++;
        if (enable_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || kp_o !== 5'd0 ||
            ki_o !== 7'd0 || best_kp_o !== 5'd0 || best_ki_o !== 7'd0 || best_score_o !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL %s: en=%0b busy=%0b done=%0b kp=%0d ki=%0d best=(%0d,%0d,%0h) expected all reset values",
                     tag, enable_o, busy_o, done_o, kp_o, ki_o, best_kp_o, best_ki_o, best_score_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; error_i = '0;
        tick(); tick();
        reset_i = 1'b0;
        check_idle_reset("reset_state");
        tick();
        check_idle_reset("idle_after_reset");
    endtask

    // Starts a sweep and follows it cycle by cycle up to cycle 'last' (1..44).
    task automatic sweep_cycles(input logic signed [7:0] e0, input logic signed [7:0] e1,
                                input logic signed [7:0] e2, input logic signed [7:0] e3,
                                input int last, input int start_at, input string tag);
        logic signed [7:0] ev [4];
        int p, o;
        logic [4:0] xkp;
        logic [6:0] xki;
        logic       xen;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        error_i = e0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) tick();
            p = (c - 1) / 11;
            o = (c - 1) % 11;
            error_i = ev[p];
            start_i = (c == start_at);
            xkp = 5'(p / 2 + 1);
            xki = 7'(p % 2 + 1);
            xen = (o >= 2);
            checks++;
            if (busy_o !== 1'b1 || done_o !== 1'b0 || enable_o !== xen || kp_o !== xkp || ki_o !== xki) begin
                errors++;
                $display("FAIL %s cyc=%0d: busy=%0b done=%0b en=%0b kp=%0d ki=%0d expected busy=1 done=0 en=%0b kp=%0d ki=%0d",
                         tag, c, busy_o, done_o, enable_o, kp_o, ki_o, xen, xkp, xki);
            end
        end
        start_i = 1'b0;
    endtask

    task automatic run_sweep(input logic signed [7:0] e0, input logic signed [7:0] e1,
                             input logic signed [7:0] e2, input logic signed [7:0] e3,
                             input int xbkp, input int xbki, input int xscore, input string tag);
        sweep_cycles(e0, e1, e2, e3, 44, -1, tag);
        tick();
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || enable_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_done cyc=45: done=%0b busy=%0b en=%0b expected done=1 busy=1 en=0",
                     tag, done_o, busy_o, enable_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || enable_o !== 1'b0 || kp_o !== 5'd0 || ki_o !== 7'd0) begin
            errors++;
            $display("FAIL %s_idle cyc=46: done=%0b busy=%0b en=%0b kp=%0d ki=%0d expected 0 0 0 0 0",
                     tag, done_o, busy_o, enable_o, kp_o, ki_o);
        end
        checks++;
        if (best_kp_o !== 5'(xbkp) || best_ki_o !== 7'(xbki)) begin
            errors++;
            $display("FAIL %s_best_gain: got (%0d,%0d) expected (%0d,%0d)", tag, best_kp_o, best_ki_o, xbkp, xbki);
        end
        checks++;
        if (best_score_o !== 24'(xscore)) begin
            errors++;
            $display("FAIL %s_best_score: got %0d expected %0d", tag, best_score_o, xscore);
        end
    endtask

    task automatic test_zero_error_sweep();
        run_sweep(8'sd0, 8'sd0, 8'sd0, 8'sd0, 1, 1, 0, "zero_err");
    endtask

    task automatic test_score_select();
        run_sweep(-8'sd128, 8'sd3, -8'sd2, 8'sd2, 2, 1, 8, "score_select");
    endtask

    task automatic test_enable_trace();
        int   lo_run, hi_run;
        logic prev_en;
        logic [4:0] prev_kp;
        logic [6:0] prev_ki;
        error_i = 8'sd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        lo_run = 0; hi_run = 0;
        prev_en = 1'b0; prev_kp = kp_o; prev_ki = ki_o;
        for (int c = 1; c <= 45; c++) begin
            if (c > 1) tick();
            if (enable_o && !prev_en) begin
                checks++;
                if (lo_run !== 2) begin
                    errors++;
                    $display("FAIL enable_low_run cyc=%0d: got %0d expected 2", c, lo_run);
                end
                hi_run = 0;
            end
            if (!enable_o && prev_en) begin
                checks++;
                if (hi_run !== 9) begin
                    errors++;
                    $display("FAIL enable_high_run cyc=%0d: got %0d expected 9", c, hi_run);
                end
                lo_run = 0;
            end
            if (enable_o && prev_en) begin
                checks++;
                if (kp_o !== prev_kp || ki_o !== prev_ki) begin
                    errors++;
                    $display("FAIL gain_stable cyc=%0d: kp/ki %0d/%0d changed from %0d/%0d while enabled",
                             c, kp_o, ki_o, prev_kp, prev_ki);
                end
            end
            if (enable_o) hi_run++; else lo_run++;
            prev_en = enable_o; prev_kp = kp_o; prev_ki = ki_o;
        end
        tick();
    endtask

    task automatic test_abort();
        sweep_cycles(8'sd1, 8'sd1, 8'sd1, 8'sd1, 20, -1, "abort_pre");
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        checks++;
        if (enable_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || kp_o !== 5'd0 || ki_o !== 7'd0) begin
            errors++;
            $display("FAIL abort_idle: en=%0b busy=%0b done=%0b kp=%0d ki=%0d expected all 0",
                     enable_o, busy_o, done_o, kp_o, ki_o);
        end
        checks++;
        if (best_kp_o !== 5'd1 || best_ki_o !== 7'd1 || best_score_o !== 24'd4) begin
            errors++;
            $display("FAIL abort_best: got (%0d,%0d,%0d) expected (1,1,4)", best_kp_o, best_ki_o, best_score_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy_o !== 1'b0 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_stays_idle +%0d: busy=%0b done=%0b expected 0 0", i, busy_o, done_o);
            end
        end
        run_sweep(8'sd7, 8'sd6, 8'sd5, 8'sd9, 2, 1, 20, "after_abort");
    endtask

    task automatic test_reset_mid_sweep();
        sweep_cycles(8'sd1, 8'sd2, 8'sd3, 8'sd4, 30, 5, "reset_pre");
        reset_i = 1'b1;
        tick();
        check_idle_reset("reset_mid_measure");
        reset_i = 1'b0;
        tick();
        check_idle_reset("reset_release");
    endtask

`ifdef GAIN_SWEEP_EARLY_ABORT_EN
    task automatic test_early_abort();
        int done_cyc;
        error_i = 8'sd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        error_i = 8'sd100;
        tick();
        error_i = 8'sd101;
        tick();
        error_i = 8'sd5;
        checks++;
        if (enable_o !== 1'b1 || kp_o !== 5'd1 || ki_o !== 7'd1) begin
            errors++;
            $display("FAIL early_abort_compare cyc=9: en=%0b kp=%0d ki=%0d expected 1 1 1", enable_o, kp_o, ki_o);
        end
        tick();
        checks++;
        if (enable_o !== 1'b0 || kp_o !== 5'd1 || ki_o !== 7'd2) begin
            errors++;
            $display("FAIL early_abort_next_hold cyc=10: en=%0b kp=%0d ki=%0d expected 0 1 2", enable_o, kp_o, ki_o);
        end
        done_cyc = -1;
        for (int c = 11; c <= 80; c++) begin
            tick();
            if (done_o === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        checks++;
        if (done_cyc !== 43) begin
            errors++;
            $display("FAIL early_abort_done_cycle: got %0d expected 43", done_cyc);
        end
        tick();
        checks++;
        if (best_kp_o !== 5'd1 || best_ki_o !== 7'd2 || best_score_o !== 24'd20) begin
            errors++;
            $display("FAIL early_abort_best: got (%0d,%0d,%0d) expected (1,2,20)", best_kp_o, best_ki_o, best_score_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_error_sweep();
        test_score_select();
        test_enable_trace();
        test_abort();
        test_reset_mid_sweep();
`ifdef GAIN_SWEEP_EARLY_ABORT_EN
        test_early_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adpll_gain_sweeper.md
Name: adpll_gain_sweeper

Overview:
Sequencer that drives the ADPLL's dynamic gain inputs through a kp/ki grid. For each gain point it resets the loop, lets it settle, and integrates |error| over a fixed window. It reports the gain pair with the lowest integrated error. It sits between the board switch/button logic and the ADPLL's kp_i, ki_i and enable_i inputs, clocked in the 258 MHz fabric domain.

Parameters:
KP_WIDTH, 5, width of kp_o / best_kp_o
KI_WIDTH, 7, width of ki_o / best_ki_o
ERR_WIDTH, 8, width of signed error_i
KP_MAX, 15, last kp value swept (first is 1)
KI_MAX, 15, last ki value swept (first is 1)
HOLD_CYCLES, 16, cycles enable_o held low per point
SETTLE_CYCLES, 4096, cycles enabled before measuring
MEAS_CYCLES, 4096, cycles of |error| accumulation
ACC_WIDTH, 24, accumulator width

Ports:
fpga_clk_i  in  1  fabric clock; all logic on rising edge
reset_i  in  1  synchronous, active-high reset
start_i  in  1  one-cycle request to begin a sweep
abort_i  in  1  stop the sweep and return to IDLE
error_i  in  ERR_WIDTH  signed phase error from the ADPLL
enable_o  out  1  ADPLL enable
kp_o  out  KP_WIDTH  current kp
ki_o  out  KI_WIDTH  current ki
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse at sweep completion
best_kp_o  out  KP_WIDTH  kp of lowest-score point
best_ki_o  out  KI_WIDTH  ki of lowest-score point
best_score_o  out  ACC_WIDTH  lowest accumulated |error|

Behaviour:
- Reset values: enable_o=0, kp_o=0, ki_o=0, busy_o=0, done_o=0, best_kp_o=0, best_ki_o=0, best_score_o=all ones, state IDLE, counters 0.
- States and transitions:
  - IDLE: start_i=1 -> HOLD with kp_o=1, ki_o=1, best_score reset to all ones, busy_o=1 from the next cycle.
  - HOLD: enable_o=0 for HOLD_CYCLES, then -> SETTLE.
  - SETTLE: enable_o=1 for SETTLE_CYCLES, then -> MEASURE with accumulator cleared.
  - MEASURE: enable_o=1 for MEAS_CYCLES; each cycle acc += |error_i|.
  - COMPARE: 1 cycle, enable_o=1.
  - DONE: done_o=1 for 1 cycle, then -> IDLE with busy_o=0.
- |error_i| rules: two's-complement magnitude, zero-extended to ACC_WIDTH; -2^(ERR_WIDTH-1) maps to 2^(ERR_WIDTH-1).
- Accumulator saturates at all ones and never wraps.
- COMPARE update: if acc < best_score (strict), load best_score/best_kp/best_ki from acc/kp_o/ki_o. Ties keep the earlier point.
- Grid order, evaluated in COMPARE: ki is the inner loop.
  - If ki_o<KI_MAX: ki_o++ and -> HOLD.
  - Else if kp_o<KP_MAX: ki_o=1, kp_o++ and -> HOLD.
  - Else -> DONE.
- Gain stability: kp_o/ki_o change only on the COMPARE->HOLD edge, so gains are stable throughout every HOLD/SETTLE/MEASURE window.
- Per-point length: HOLD+SETTLE+MEAS+1 cycles. Total sweep: KP_MAX*KI_MAX points, plus 1 DONE cycle.
- start_i while busy_o=1 is ignored.
- abort_i in any non-IDLE state -> IDLE next cycle:
  - enable_o=0, kp_o/ki_o=0, busy_o=0, no done_o.
  - best_* retains its last committed value.
  - abort_i wins over a simultaneous start_i.
- reset_i mid-sweep: all outputs return to reset values on the next edge.
- In IDLE, outputs hold their reset values or last values: enable_o=0, kp_o/ki_o=0, best_* held.

Optional Feature:
GAIN_SWEEP_EARLY_ABORT_EN.
- With the macro: extra parameter ABORT_THRESH (default 100). In MEASURE, if |error_i| > ABORT_THRESH, the window ends immediately and -> COMPARE with acc forced to all ones, so the point cannot become best. Point length shortens accordingly.
- Without the macro: MEASURE always runs the full MEAS_CYCLES; no threshold logic is present.

Test Plan:
Common bench parameters: KP_MAX=2, KI_MAX=2, HOLD=2, SETTLE=4, MEAS=4.
1. Reset, then hold error_i=0 and pulse start_i -> busy_o rises 1 cycle later; points visited (1,1),(1,2),(2,1),(2,2) at 11-cycle spacing; done_o pulses once at cycle 45; best=(1,1), score 0.
2. error_i=-128 constant for (1,1), +3 for (1,2), -2 for (2,1), +2 for (2,2) -> scores 512,12,8,8; best=(2,1), score 8 (tie keeps earlier).
3. enable_o trace -> 0 for exactly 2 cycles before each point, 1 for 9 cycles; kp_o/ki_o never change while enable_o=1.
4. abort_i at cycle 20 with start_i also high -> IDLE next cycle; enable_o=0, busy_o=0, no done_o; best reflects (1,1) only. A second start_i then runs a full sweep.
5. reset_i asserted during MEASURE of point (2,1) -> all outputs at reset values on the next edge; start_i pulsed during the sweep is ignored.
6. With GAIN_SWEEP_EARLY_ABORT_EN, ABORT_THRESH=100, error_i=101 for one cycle in MEASURE of (1,1) -> COMPARE next cycle; (1,1) never becomes best even if the other scores are all ones-1.
